// File: rtl/axil_mem2p_rd_if.sv
// AXI4-Lite read-channel bundle (AR + R) between a master and the axil_mem2p_rd responder.
interface axil_mem2p_rd_if #(
    parameter int G_DATAWIDTH     = 32,
    parameter int G_AXI_ADDRWIDTH = 32
);
    logic [G_AXI_ADDRWIDTH-1:0] araddr;
    logic                       arvalid;
    logic                       arready;
    logic [G_DATAWIDTH-1:0]     rdata;
    logic [1:0]                 rresp;
    logic                       rvalid;
    logic                       rready;

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_mem2p_rd.sv
// AXI4-Lite read responder on memory port B; optional range check via AXIL_MEM_RD_RANGECHK_EN.
// Latency: enb/addrb same cycle as AR handshake, R beat valid two cycles later.
// Backpressure: 3 credits cover in-flight read + response FIFO; arready is registered, never sees rready.
module axil_mem2p_rd #(
    parameter int G_DATAWIDTH     = 32,
    parameter int G_MEMDEPTH      = 1024,
    parameter int G_ADDRWIDTH     = $clog2(G_MEMDEPTH),
    parameter int G_AXI_ADDRWIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    axil_mem2p_rd_if.slave         s,
    output logic                   enb,
    output logic [G_ADDRWIDTH-1:0] addrb,
    input  logic [G_DATAWIDTH-1:0] doutb
);
    localparam int SHIFT = $clog2(G_DATAWIDTH / 8);
    localparam int DEPTH = 3;

    logic [G_AXI_ADDRWIDTH-1:0] word_full;
    logic                       ar_hs;
    logic                       req_err;
    logic                       arready_q;
    logic                       rvalid_q;
    logic                       rvalid_out;
    logic                       infl;
    logic                       infl_err;
    logic                       push;
    logic                       pop;
    logic [G_DATAWIDTH-1:0]     push_dat;
    logic [1:0]                 push_resp;
    logic [1:0]                 cnt;
    logic [1:0]                 cnt_nxt;
    logic [1:0]                 wr_idx;
    logic [2:0]                 out_nxt;
    logic [G_DATAWIDTH-1:0]     q_dat    [DEPTH];
    logic [1:0]                 q_resp   [DEPTH];
    logic [G_DATAWIDTH-1:0]     nxt_dat  [DEPTH];
    logic [1:0]                 nxt_resp [DEPTH];

    assign word_full = s.araddr >> SHIFT;

`ifdef AXIL_MEM_RD_RANGECHK_EN
    assign req_err = (word_full >= G_AXI_ADDRWIDTH'(G_MEMDEPTH));
    logic unused_bits;
    assign unused_bits = ^s.araddr[SHIFT-1:0];
`else
    assign req_err = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{s.araddr[SHIFT-1:0], word_full[G_AXI_ADDRWIDTH-1:G_ADDRWIDTH]};
`endif

    // arready/rvalid are forced low while rst is high so reset is visible in the same cycle
    assign s.arready  = arready_q & ~rst;
    assign rvalid_out = rvalid_q & ~rst;
    assign s.rvalid   = rvalid_out;
    assign s.rdata    = q_dat[0];
    assign s.rresp    = q_resp[0];

    assign ar_hs = s.arvalid & s.arready;
    assign enb   = ar_hs & ~req_err;
    assign addrb = enb ? word_full[G_ADDRWIDTH-1:0] : '0;

    assign push      = infl;
    assign pop       = rvalid_out & s.rready;
    assign push_dat  = infl_err ? '0 : doutb;
    assign push_resp = infl_err ? 2'b10 : 2'b00;
    assign cnt_nxt   = cnt + {1'b0, push} - {1'b0, pop};
    assign wr_idx    = cnt - {1'b0, pop};
    assign out_nxt   = {1'b0, cnt_nxt} + {2'b00, ar_hs};

    // Shift-register FIFO: entry 0 is the registered R head
    always_comb begin
        nxt_dat  = q_dat;
        nxt_resp = q_resp;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                nxt_dat[i]  = q_dat[i+1];
                nxt_resp[i] = q_resp[i+1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_idx == 2'(i))) begin
                nxt_dat[i]  = push_dat;
                nxt_resp[i] = push_resp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            infl      <= 1'b0;
            infl_err  <= 1'b0;
            cnt       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_dat[i]  <= '0;
                q_resp[i] <= '0;
            end
        end else begin
            arready_q <= (out_nxt < 3'd3);
            rvalid_q  <= (cnt_nxt != 2'd0);
            infl      <= ar_hs;
            infl_err  <= ar_hs & req_err;
            cnt       <= cnt_nxt;
            q_dat     <= nxt_dat;
            q_resp    <= nxt_resp;
        end
    end
endmodule
